// File: rtl/fdd_rotation_if.sv
// Disk-side signal bundle for fdd_rotation: motor/timing inputs, track buffer
// read port and the rotating byte stream with its index pulse.
interface fdd_rotation_if;
   logic        msclk;
   logic        MOTORn;
   logic        track_ready;
   logic [12:0] buffer_addr;
   logic [7:0]  buffer_q;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        INDEXn;
   logic        rot_ready;

   modport master (
      output msclk, MOTORn, track_ready, buffer_q,
      input  buffer_addr, byte_data, byte_valid, INDEXn, rot_ready
   );

   modport slave (
      input  msclk, MOTORn, track_ready, buffer_q,
      output buffer_addr, byte_data, byte_valid, INDEXn, rot_ready
   );
endinterface

// File: rtl/fdd_rotation.sv
// Floppy spindle model: streams track-buffer bytes at disk rate and drives INDEXn.
// FDD_SPINUP_EN adds a SPINUP state that waits SPINUP_MS msclk strobes before RUN.
module fdd_rotation #(
   parameter int BYTE_DIV    = 687,
   parameter int TRACK_BYTES = 6250,
   parameter int INDEX_BYTES = 8,
   parameter int SPINUP_MS   = 500
) (
   input  logic          clk,
   input  logic          reset_n,
   fdd_rotation_if.slave bus
);
   localparam int              DW       = (BYTE_DIV > 2) ? $clog2(BYTE_DIV) : 1;
   localparam logic [DW-1:0]   DIV_MAX  = DW'(BYTE_DIV - 1);
   localparam logic [12:0]     POS_LAST = 13'(TRACK_BYTES - 1);
   localparam logic [12:0]     IDX_END  = 13'(INDEX_BYTES);

`ifdef FDD_SPINUP_EN
   localparam int              SW       = (SPINUP_MS > 0) ? $clog2(SPINUP_MS + 1) : 1;
   localparam logic [SW-1:0]   SPIN_MAX = SW'(SPINUP_MS);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SPINUP = 2'd1,
      ST_RUN    = 2'd2
   } state_t;

   logic [SW-1:0] spin_q, spin_d;
`else
   localparam int unused_spinup_ms = SPINUP_MS;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd2
   } state_t;

   logic unused_msclk_s;
   assign unused_msclk_s = bus.msclk;
`endif

   state_t        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [12:0]   pos_q, pos_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          indexn_q;
   logic          rot_q;

   // Next-state logic; motor-off overrides everything, including a pending tick.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      pos_d   = pos_q;
      data_d  = data_q;
      valid_d = 1'b0;
`ifdef FDD_SPINUP_EN
      spin_d  = spin_q;
`endif
      if (bus.MOTORn) begin
         state_d = ST_IDLE;
         div_d   = '0;
      end else begin
         case (state_q)
`ifdef FDD_SPINUP_EN
            ST_IDLE: begin
               state_d = ST_SPINUP;
               spin_d  = '0;
            end
            ST_SPINUP: begin
               if (spin_q == SPIN_MAX) begin
                  state_d = ST_RUN;
               end else if (bus.msclk) begin
                  spin_d = spin_q + SW'(1);
               end else begin
                  spin_d = spin_q;
               end
            end
`else
            ST_IDLE: begin
               state_d = ST_RUN;
            end
`endif
            ST_RUN: begin
               if (div_q == DIV_MAX) begin
                  // buffer_q has held the byte at pos_q since one cycle after pos_q settled
                  div_d   = '0;
                  pos_d   = (pos_q == POS_LAST) ? 13'd0 : pos_q + 13'd1;
                  data_d  = bus.buffer_q;
                  valid_d = bus.track_ready;
               end else begin
                  div_d = div_q + DW'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               div_d   = '0;
            end
         endcase
      end
   end

   // State and registered outputs; INDEXn/rot_ready follow the post-update state and pos.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         div_q    <= '0;
         pos_q    <= 13'd0;
         data_q   <= 8'h00;
         valid_q  <= 1'b0;
         indexn_q <= 1'b1;
         rot_q    <= 1'b0;
`ifdef FDD_SPINUP_EN
         spin_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         pos_q    <= pos_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         indexn_q <= !((state_d == ST_RUN) && (pos_d < IDX_END));
         rot_q    <= (state_d == ST_RUN);
`ifdef FDD_SPINUP_EN
         spin_q   <= spin_d;
`endif
      end
   end

   assign bus.buffer_addr = pos_q;
   assign bus.byte_data   = data_q;
   assign bus.byte_valid  = valid_q;
   assign bus.INDEXn      = indexn_q;
   assign bus.rot_ready   = rot_q;
endmodule

// File: tb/tb_fdd_rotation.sv
// Directed bench for fdd_rotation with BYTE_DIV=4, TRACK_BYTES=16, INDEX_BYTES=2,
// SPINUP_MS=3; the track buffer returns its own address one cycle later.
module tb_fdd_rotation;
   logic clk;
   logic reset_n;
   int   n_total;
   int   n_bad;

   fdd_rotation_if bus ();

   fdd_rotation #(
      .BYTE_DIV   (4),
      .TRACK_BYTES(16),
      .INDEX_BYTES(2),
      .SPINUP_MS  (3)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Track buffer: data equals address, one cycle read latency.
   always @(posedge clk) bus.buffer_q <= bus.buffer_addr[7:0];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Turns the motor on and returns just after the first edge in RUN.
   task automatic motor_start();
      logic found;
      bus.MOTORn = 1'b0;
`ifdef FDD_SPINUP_EN
      step();
      check("spin_idle_rdy", bus.rot_ready, 1'b0);
      for (int s = 0; s < 3; s++) begin
         bus.msclk = 1'b1;
         step();
         bus.msclk = 1'b0;
         if (s < 2) begin
            step();
            step();
         end
         if (s == 1) check("spin_early_rdy", bus.rot_ready, 1'b0);
      end
      check("spin_third_rdy", bus.rot_ready, 1'b0);
      found = 1'b0;
      for (int w = 0; w < 6 && !found; w++) begin
         step();
         if (bus.rot_ready) found = 1'b1;
      end
      check("spin_done_rdy", found, 1'b1);
`else
      check("motor_idle_rdy", bus.rot_ready, 1'b0);
      step();
      check("motor_run_rdy", bus.rot_ready, 1'b1);
`endif
   endtask

   initial begin
      logic found;
      int   k;
      n_total         = 0;
      n_bad           = 0;
      reset_n         = 1'b1;
      bus.MOTORn      = 1'b1;
      bus.track_ready = 1'b1;
      bus.msclk       = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_addr",   bus.buffer_addr, 13'd0);
      check("rst_data",   bus.byte_data,   8'h00);
      check("rst_valid",  bus.byte_valid,  1'b0);
      check("rst_indexn", bus.INDEXn,      1'b1);
      check("rst_ready",  bus.rot_ready,   1'b0);
      step();
      step();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      step();
      step();
      check("idle_ready", bus.rot_ready, 1'b0);

      // Rotation: byte k appears at edge 5+4k, INDEXn low for edges 1..8 of every 64.
      motor_start();
      check("run_indexn_start", bus.INDEXn, 1'b0);
      for (int n = 2; n <= 168; n++) begin
         step();
         if (n == 2) check("run_ready", bus.rot_ready, 1'b1);
         if (n >= 5 && ((n - 5) % 4) == 0) begin
            k = (n - 5) / 4;
            check("byte_data",  bus.byte_data,  k % 16);
            check("byte_valid", bus.byte_valid, (k >= 5 && k <= 7) ? 1'b0 : 1'b1);
         end else begin
            check("byte_valid_idle", bus.byte_valid, 1'b0);
         end
         check("indexn", bus.INDEXn, (((n - 1) % 64) < 8) ? 1'b0 : 1'b1);
         bus.track_ready = (n >= 24 && n <= 32) ? 1'b0 : 1'b1;
         if (n == 168) bus.MOTORn = 1'b1;
      end

      // Motor off on the tick at pos 9.
      step();
      check("off_valid",  bus.byte_valid,  1'b0);
      check("off_indexn", bus.INDEXn,      1'b1);
      check("off_ready",  bus.rot_ready,   1'b0);
      check("off_addr",   bus.buffer_addr, 13'd9);
      check("off_data",   bus.byte_data,   8'd8);
      step();
      step();
      step();
      check("off_addr_held", bus.buffer_addr, 13'd9);
      motor_start();
      check("resume_addr",   bus.buffer_addr, 13'd9);
      check("resume_indexn", bus.INDEXn,      1'b1);
      for (int j = 1; j <= 4; j++) begin
         step();
         if (j == 4) begin
            check("resume_valid", bus.byte_valid,  1'b1);
            check("resume_data",  bus.byte_data,   8'd9);
            check("resume_addr2", bus.buffer_addr, 13'd10);
         end else begin
            check("resume_wait", bus.byte_valid, 1'b0);
         end
      end

      // Asynchronous reset in the middle of the byte at pos 6.
      found = 1'b0;
      for (int w = 0; w < 100 && !found; w++) begin
         step();
         if (bus.buffer_addr == 13'd6) found = 1'b1;
      end
      check("wait_pos6", found, 1'b1);
      step();
      reset_n = 1'b0;
      #1;
      check("mid_rst_addr",   bus.buffer_addr, 13'd0);
      check("mid_rst_data",   bus.byte_data,   8'h00);
      check("mid_rst_valid",  bus.byte_valid,  1'b0);
      check("mid_rst_indexn", bus.INDEXn,      1'b1);
      check("mid_rst_ready",  bus.rot_ready,   1'b0);
      #2;
      reset_n = 1'b1;
      motor_start();
      for (int j = 1; j <= 4; j++) begin
         step();
         if (j == 4) begin
            check("restart_valid", bus.byte_valid, 1'b1);
            check("restart_data",  bus.byte_data,  8'd0);
         end else begin
            check("restart_wait", bus.byte_valid, 1'b0);
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
